// File: rtl/series_eval.sv
// Iterative Taylor-series evaluator for sin/cos/sinh/cosh with an external coefficient table.
// Latency: done 1+3*terms cycles after the start edge; start is ignored while busy, with no other backpressure.
module series_eval (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  fsel,
    input  logic [7:0]  x,
    input  logic [3:0]  terms,
    output logic        tbl_func,
    output logic [3:0]  tbl_addr,
    input  logic [7:0]  tbl_data,
    output logic        busy,
    output logic        done,
    output logic [17:0] result
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_FETCH, S_MUL1, S_MUL2, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        hyp_q, hyp_d;
    logic        tbl_func_q, tbl_func_d;
    logic [7:0]  x_q, x_d;
    logic [3:0]  terms_q, terms_d;
    logic [7:0]  x2_q, x2_d;
    logic [4:0]  k_q, k_d;
    logic [17:0] term_q, term_d;
    logic [17:0] acc_q, acc_d;
    logic [17:0] p_q, p_d;
    logic [7:0]  coef_q, coef_d;
    logic [17:0] result_q, result_d;
    logic [3:0]  tbl_addr_q, tbl_addr_d;

    logic [17:0] term_init;
    logic [17:0] term_new;
    logic [18:0] acc_sum;
    logic        do_sub;

    always_comb begin
        term_init = tbl_func_q ? 18'h10000 : {2'b00, x_q, 8'h00};
        term_new  = 18'(({8'd0, p_q} * {18'd0, coef_q}) >> 8);
        acc_sum   = {1'b0, acc_q} + {1'b0, term_new};
        // Alternating signs only for the trigonometric chains: odd terms subtract.
        do_sub    = !hyp_q && k_q[0];
    end

    always_comb begin
        state_d    = state_q;
        hyp_d      = hyp_q;
        tbl_func_d = tbl_func_q;
        x_d        = x_q;
        terms_d    = terms_q;
        x2_d       = x2_q;
        k_d        = k_q;
        term_d     = term_q;
        acc_d      = acc_q;
        p_d        = p_q;
        coef_d     = coef_q;
        result_d   = result_q;
        tbl_addr_d = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hyp_d      = fsel[1];
                    tbl_func_d = fsel[0];
                    x_d        = x;
                    terms_d    = terms;
                    state_d    = S_INIT;
                end
            end
            S_INIT: begin
                x2_d    = 8'(({8'd0, x_q} * {8'd0, x_q}) >> 8);
                k_d     = 5'd1;
                term_d  = term_init;
                acc_d   = term_init;
                state_d = (terms_q != 4'd0) ? S_FETCH : S_DONE;
            end
            S_FETCH: begin
                coef_d  = tbl_data;
                state_d = S_MUL1;
            end
            S_MUL1: begin
                p_d     = 18'(({8'd0, term_q} * {18'd0, x2_q}) >> 8);
                state_d = S_MUL2;
            end
            S_MUL2: begin
                term_d = term_new;
                if (do_sub)
                    acc_d = (acc_q >= term_new) ? acc_q - term_new : 18'd0;
                else
                    acc_d = acc_sum[18] ? 18'h3FFFF : acc_sum[17:0];
                k_d     = k_q + 5'd1;
                state_d = (k_q < {1'b0, terms_q}) ? S_FETCH : S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Address and result are registered on entry so they are valid during FETCH/DONE.
        if (state_d == S_FETCH)
            tbl_addr_d = k_d[3:0];
        if (state_d == S_DONE)
            result_d = acc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hyp_q      <= 1'b0;
            tbl_func_q <= 1'b0;
            x_q        <= 8'd0;
            terms_q    <= 4'd0;
            x2_q       <= 8'd0;
            k_q        <= 5'd0;
            term_q     <= 18'd0;
            acc_q      <= 18'd0;
            p_q        <= 18'd0;
            coef_q     <= 8'd0;
            result_q   <= 18'd0;
            tbl_addr_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            hyp_q      <= hyp_d;
            tbl_func_q <= tbl_func_d;
            x_q        <= x_d;
            terms_q    <= terms_d;
            x2_q       <= x2_d;
            k_q        <= k_d;
            term_q     <= term_d;
            acc_q      <= acc_d;
            p_q        <= p_d;
            coef_q     <= coef_d;
            result_q   <= result_d;
            tbl_addr_q <= tbl_addr_d;
        end
    end

    assign tbl_func = tbl_func_q;
    assign tbl_addr = tbl_addr_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
endmodule

// File: tb/tb_series_eval.sv
// Directed bench for series_eval with a behavioural Taylor coefficient table.
module tb_series_eval;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  fsel;
    logic [7:0]  x;
    logic [3:0]  terms;
    logic        tbl_func;
    logic [3:0]  tbl_addr;
    logic [7:0]  tbl_data;
    logic        busy;
    logic        done;
    logic [17:0] result;

    int tests = 0;
    int fails = 0;

    series_eval dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .fsel     (fsel),
        .x        (x),
        .terms    (terms),
        .tbl_func (tbl_func),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    // floor(256 / denominator) of the Taylor recurrence for each chain
    function automatic logic [7:0] coef_of(input logic func, input logic [3:0] addr);
        int a, d;
        a = int'(addr);
        if (a == 0) return 8'd0;
        d = func ? (2*a - 1) * (2*a) : (2*a) * (2*a + 1);
        return 8'(256 / d);
    endfunction

    assign tbl_data = coef_of(tbl_func, tbl_addr);

    function automatic logic [17:0] model(input logic [1:0] f, input logic [7:0] xv, input logic [3:0] t);
        logic [7:0]  x2;
        logic [17:0] term, acc, p;
        logic [18:0] s;
        x2   = 8'(({8'd0, xv} * {8'd0, xv}) >> 8);
        term = f[0] ? 18'h10000 : {2'b00, xv, 8'h00};
        acc  = term;
        for (int k = 1; k <= int'(t); k++) begin
            p    = 18'(({8'd0, term} * {18'd0, x2}) >> 8);
            term = 18'(({8'd0, p} * {18'd0, coef_of(f[0], 4'(k))}) >> 8);
            if (!f[1] && (k % 2 == 1)) begin
                acc = (acc >= term) ? acc - term : 18'd0;
            end else begin
                s   = {1'b0, acc} + {1'b0, term};
                acc = s[18] ? 18'h3FFFF : s[17:0];
            end
        end
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] f, input logic [7:0] xv, input logic [3:0] t,
                       input logic [17:0] exp, input string tag, input bit poke);
        int n;
        start = 1'b1; fsel = f; x = xv; terms = t;
        step();
        start = 1'b0; fsel = ~f; x = ~xv; terms = ~t;
        chk({tag, " init busy"}, 32'(busy), 32'd1);
        chk({tag, " init addr"}, 32'(tbl_addr), 32'd0);
        chk({tag, " tbl_func"}, 32'(tbl_func), 32'(f[0]));
        n = 1 + 3 * int'(t);
        for (int i = 1; i <= n; i++) begin
            step();
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " done"}, 32'(done), (i == n) ? 32'd1 : 32'd0);
            chk({tag, " addr"}, 32'(tbl_addr), (i < n && i % 3 == 1) ? 32'((i + 2) / 3) : 32'd0);
            if (i == n) chk({tag, " result"}, 32'(result), 32'(exp));
            start = (poke && (i == 2 || i == n)) ? 1'b1 : 1'b0;
        end
        step();
        start = 1'b0;
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " done pulse"}, 32'(done), 32'd0);
        chk({tag, " result held"}, 32'(result), 32'(exp));
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; fsel = 2'b00; x = 8'h00; terms = 4'd0;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst addr", 32'(tbl_addr), 32'd0);
        chk("rst func", 32'(tbl_func), 32'd0);
        chk("rst result", 32'(result), 32'd0);
        step(); step();
        rst = 1'b0;

        run(2'b00, 8'h80, 4'd1,  18'h07AC0, "sin80_1", 1'b0);
        run(2'b01, 8'h80, 4'd1,  18'h0E000, "cos80_1", 1'b0);
        run(2'b11, 8'h80, 4'd1,  18'h12000, "cosh80_1", 1'b0);
        run(2'b01, 8'h00, 4'd15, 18'h10000, "cos00_15", 1'b0);
        run(2'b00, 8'hFF, 4'd0,  18'h0FF00, "sinFF_0", 1'b0);
        run(2'b11, 8'hFF, 4'd15, model(2'b11, 8'hFF, 4'd15), "coshFF_15", 1'b0);
        run(2'b10, 8'hC0, 4'd4,  model(2'b10, 8'hC0, 4'd4), "sinhC0_4", 1'b0);
        run(2'b01, 8'h80, 4'd1,  18'h0E000, "cos_poke", 1'b1);

        // Abort during MUL1 of term 3 (edge E0+8)
        start = 1'b1; fsel = 2'b11; x = 8'h80; terms = 4'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("abort pre busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort addr", 32'(tbl_addr), 32'd0);
        chk("abort func", 32'(tbl_func), 32'd0);
        chk("abort result", 32'(result), 32'd0);
        step();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) done_seen++;
        end
        chk("abort no done", 32'(done_seen), 32'd0);
        run(2'b11, 8'h80, 4'd1, 18'h12000, "post_abort", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
